// File: rtl/instr_fetch_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM encoding and fetch defaults.
// Imported by the fetch unit and the control decoder.
package instr_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_MAX_WAIT = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2,
        ERROR      = 2'd3
    } fetch_state_e;

    // Branch displacement in bytes: sign-extended word offset shifted left by two.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_npc_sel.sv
// Next-PC selection for the retiring instruction: jr, j, taken branch or fall-through.
// Purely combinational; the fetch FSM decides when the result is committed.
module npc_sel
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [25:0] instr_i,
    input  logic        branch_i,
    input  logic        branch_ne_i,
    input  logic        zero_i,
    input  logic        mux_branch_jump_i,
    input  logic        mux_j_type_addr_to_read_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] npc_o,
    output logic        misaligned_o
);

    logic branch_taken;

    assign branch_taken = branch_i && (zero_i ^ branch_ne_i);

    always_comb begin
        if (!mux_j_type_addr_to_read_i) begin
            npc_o = rs_data_i;
        end else if (!mux_branch_jump_i) begin
            npc_o = {pc_plus4_i[31:28], instr_i, 2'b00};
        end else if (branch_taken) begin
            npc_o = pc_plus4_i + branch_offset(instr_i[15:0]);
        end else begin
            npc_o = pc_plus4_i;
        end
    end

    // Only a register target can be misaligned; all other targets are built word-aligned.
    assign misaligned_o = !mux_j_type_addr_to_read_i && (rs_data_i[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word fetches, holds the instruction for decode
// until retired, then fetches from the selected next PC. Timeouts and bad jr targets are sticky.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        exec_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic        mux_branch_jump,
    input  logic        mux_j_type_addr_to_read,
    input  logic [31:0] rs_data,
    output logic        fetch_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    logic [31:0]   npc;
    logic          npc_misaligned;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign instr     = instr_q;
    assign opcode    = instr_q[31:26];
    assign fetch_err = err_q;

    npc_sel u_npc_sel (
        .pc_plus4_i                (pc_plus4),
        .instr_i                   (instr_q[25:0]),
        .branch_i                  (branch),
        .branch_ne_i               (branch_ne),
        .zero_i                    (zero),
        .mux_branch_jump_i         (mux_branch_jump),
        .mux_j_type_addr_to_read_i (mux_j_type_addr_to_read),
        .rs_data_i                 (rs_data),
        .npc_o                     (npc),
        .misaligned_o              (npc_misaligned)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        wait_d      = wait_q;
        err_d       = err_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            RESET_WAIT: begin
                wait_d  = '0;
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                // Data arriving on the last tolerated cycle still wins over the timeout.
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                    state_d = HOLD;
                end else if (wait_q == CW'(MAX_WAIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (exec_ack) begin
                    if (npc_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        pc_d    = npc;
                        state_d = FETCH;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_WAIT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of next-PC vectors plus directed
// sequences for reset timing, timeout boundary, bad jr target and reset in HOLD.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          MAXW     = 16;
    localparam logic [31:0] JR_WORD  = 32'h03E0_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        exec_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch = 1'b0;
    logic        branch_ne = 1'b0;
    logic        zero = 1'b0;
    logic        mux_branch_jump = 1'b1;
    logic        mux_j_type_addr_to_read = 1'b1;
    logic [31:0] rs_data = 32'h0;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ready              (imem_ready),
        .imem_rdata              (imem_rdata),
        .instr                   (instr),
        .opcode                  (opcode),
        .instr_valid             (instr_valid),
        .exec_ack                (exec_ack),
        .pc                      (pc),
        .pc_plus4                (pc_plus4),
        .branch                  (branch),
        .branch_ne               (branch_ne),
        .zero                    (zero),
        .mux_branch_jump         (mux_branch_jump),
        .mux_j_type_addr_to_read (mux_j_type_addr_to_read),
        .rs_data                 (rs_data),
        .fetch_err               (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic [31:0] word;
        logic        mux_j;
        logic        mux_bj;
        logic        br;
        logic        bne;
        logic        z;
        logic [31:0] rs;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl_idle();
        mux_j_type_addr_to_read = 1'b1;
        mux_branch_jump         = 1'b1;
        branch                  = 1'b0;
        branch_ne               = 1'b0;
        zero                    = 1'b0;
        rs_data                 = 32'h0;
    endtask

    task automatic serve(input logic [31:0] word, input int delay);
        imem_ready = 1'b0;
        for (int i = 0; i < delay; i++) step();
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic ack(input logic mj, input logic mbj, input logic br, input logic bne,
                       input logic z, input logic [31:0] rs);
        mux_j_type_addr_to_read = mj;
        mux_branch_jump         = mbj;
        branch                  = br;
        branch_ne               = bne;
        zero                    = z;
        rs_data                 = rs;
        exec_ack                = 1'b1;
        step();
        exec_ack = 1'b0;
        set_ctrl_idle();
    endtask

    task automatic reset_enter();
        rst = 1'b1;
        imem_ready = 1'b0;
        exec_ack = 1'b0;
        step();
        step();
    endtask

    initial begin
        vecs[0]  = '{"beq_taken_back",  32'h0000_0010, 32'h1000_FFFF, 1, 1, 1, 0, 1, 32'h0, 32'h0000_0010};
        vecs[1]  = '{"beq_not_taken",   32'h0000_0010, 32'h1000_FFFF, 1, 1, 1, 0, 0, 32'h0, 32'h0000_0014};
        vecs[2]  = '{"bne_taken",       32'h0000_0020, 32'h1400_0003, 1, 1, 1, 1, 0, 32'h0, 32'h0000_0030};
        vecs[3]  = '{"bne_not_taken",   32'h0000_0020, 32'h1400_0003, 1, 1, 1, 1, 1, 32'h0, 32'h0000_0024};
        vecs[4]  = '{"j_region",        32'h4000_0000, 32'h0800_0100, 1, 0, 0, 0, 0, 32'h0, 32'h4000_0400};
        vecs[5]  = '{"jr_aligned",      32'h0000_0100, JR_WORD,       0, 1, 0, 0, 0, 32'h0000_2000, 32'h0000_2000};
        vecs[6]  = '{"wrap_plus4",      32'hFFFF_FFFC, 32'h0000_0000, 1, 1, 0, 0, 0, 32'h0, 32'h0000_0000};
        vecs[7]  = '{"branch_disabled", 32'h0000_0040, 32'h1000_FFFF, 1, 1, 0, 0, 1, 32'h0, 32'h0000_0044};
        vecs[8]  = '{"jr_priority",     32'h0000_0050, 32'h1000_0004, 0, 0, 1, 0, 1, 32'h0000_0600, 32'h0000_0600};
        vecs[9]  = '{"j_top_region",    32'hF000_0010, 32'h0BFF_FFFF, 1, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC};
        vecs[10] = '{"beq_far_back",    32'h0000_1000, 32'h1000_8000, 1, 1, 1, 0, 1, 32'h0, 32'hFFFE_1004};

        // Reset state and first fetch timing.
        reset_enter();
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'h0);
        rst = 1'b0;
        check("c1_reset_wait_req", {31'b0, imem_req}, 32'h0);
        step();
        check("c2_fetch_req", {31'b0, imem_req}, 32'h1);
        check("c2_fetch_addr", imem_addr, 32'h0000_0000);
        // exec_ack outside HOLD must be ignored.
        mux_j_type_addr_to_read = 1'b0;
        rs_data = 32'h0000_0100;
        exec_ack = 1'b1;
        step();
        exec_ack = 1'b0;
        set_ctrl_idle();
        check("c3_addr_after_stray_ack", imem_addr, 32'h0000_0000);
        check("c3_not_valid", {31'b0, instr_valid}, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_ready = 1'b0;
        check("c4_instr_valid", {31'b0, instr_valid}, 32'h1);
        check("c4_opcode", {26'b0, opcode}, {26'b0, 6'b001000});
        check("c4_instr", instr, 32'h2008_0005);
        check("c4_req_low", {31'b0, imem_req}, 32'h0);
        ack(1, 1, 0, 0, 0, 32'h0);
        check("bubble_valid", {31'b0, instr_valid}, 32'h0);
        check("bubble_addr", imem_addr, 32'h0000_0004);

        // Next-PC table: jr to the start PC, fetch the vector word, retire it, check the next fetch.
        for (int i = 0; i < 11; i++) begin
            serve(JR_WORD, 0);
            ack(0, 1, 0, 0, 0, vecs[i].start_pc);
            check({vecs[i].name, "_start_addr"}, imem_addr, vecs[i].start_pc);
            serve(vecs[i].word, i % 3);
            check({vecs[i].name, "_hold_instr"}, instr, vecs[i].word);
            check({vecs[i].name, "_pc_plus4"}, pc_plus4, vecs[i].start_pc + 32'd4);
            ack(vecs[i].mux_j, vecs[i].mux_bj, vecs[i].br, vecs[i].bne, vecs[i].z, vecs[i].rs);
            check({vecs[i].name, "_bubble_valid"}, {31'b0, instr_valid}, 32'h0);
            check({vecs[i].name, "_next_addr"}, imem_addr, vecs[i].exp_addr);
            check({vecs[i].name, "_err"}, {31'b0, fetch_err}, 32'h0);
        end

        // Misaligned jr target: sticky error, pc unchanged, terminal.
        serve(32'h0000_0000, 0);
        check("jr_bad_pre_pc", pc, vecs[10].exp_addr);
        ack(0, 1, 0, 0, 0, 32'h0000_0102);
        check("jr_bad_err", {31'b0, fetch_err}, 32'h1);
        check("jr_bad_pc_kept", pc, vecs[10].exp_addr);
        check("jr_bad_req", {31'b0, imem_req}, 32'h0);
        imem_ready = 1'b1;
        exec_ack = 1'b1;
        step();
        step();
        imem_ready = 1'b0;
        exec_ack = 1'b0;
        check("error_terminal_err", {31'b0, fetch_err}, 32'h1);
        check("error_terminal_req", {31'b0, imem_req}, 32'h0);
        check("error_terminal_valid", {31'b0, instr_valid}, 32'h0);

        // Timeout: MAX_WAIT misses raise the error, one fewer does not.
        reset_enter();
        rst = 1'b0;
        step();
        for (int i = 0; i < MAXW - 1; i++) step();
        check("to_before_err", {31'b0, fetch_err}, 32'h0);
        check("to_before_req", {31'b0, imem_req}, 32'h1);
        step();
        check("to_err", {31'b0, fetch_err}, 32'h1);
        check("to_req_low", {31'b0, imem_req}, 32'h0);

        // Ready on the final tolerated cycle is accepted.
        reset_enter();
        rst = 1'b0;
        step();
        serve(32'h8C01_0004, MAXW - 1);
        check("late_ok_valid", {31'b0, instr_valid}, 32'h1);
        check("late_ok_err", {31'b0, fetch_err}, 32'h0);
        check("late_ok_instr", instr, 32'h8C01_0004);

        // Reset asserted while holding the instruction at 0x80.
        ack(0, 1, 0, 0, 0, 32'h0000_0080);
        serve(32'h2008_0001, 1);
        check("hold80_pc", pc, 32'h0000_0080);
        check("hold80_valid", {31'b0, instr_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_hold_valid_now", {31'b0, instr_valid}, 32'h0);
        check("rst_hold_pc_now", pc, RST_PC);
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        rst = 1'b0;
        check("post_rst_wait_req", {31'b0, imem_req}, 32'h0);
        step();
        imem_ready = 1'b0;
        check("post_rst_fetch_req", {31'b0, imem_req}, 32'h1);
        check("post_rst_fetch_addr", imem_addr, RST_PC);
        check("post_rst_late_ready_ignored", {31'b0, instr_valid}, 32'h0);
        check("post_rst_instr", instr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
